// File: rtl/regfile_param.sv
// Parameterised multi-read-port register file with a one-register-per-cycle clear sweep.
// Optional write-first read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_param #(
   parameter int DATA_W    = 64,
   parameter int ADDR_W    = 5,
   parameter int NUM_RD    = 2,
   parameter int ZERO_LAST = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       write,
   input  logic [ADDR_W-1:0]          wrAddr,
   input  logic [DATA_W-1:0]          wrData,
   input  logic                       clr,
   input  logic [NUM_RD*ADDR_W-1:0]   rdAddr,
   output logic [NUM_RD*DATA_W-1:0]   rdData,
   output logic                       busy,
   output logic                       wrDrop
);

   // state | meaning
   // IDLE  | normal read/write operation
   // SWEEP | zeroing register cnt each cycle, writes dropped
   typedef enum logic {IDLE, SWEEP} state_t;

   localparam int                DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST  = {ADDR_W{1'b1}};

   state_t              state, state_nx;
   logic [ADDR_W-1:0]   cnt, cnt_nx;
   logic [DATA_W-1:0]   regs [DEPTH];
   logic                wr_zero;
   logic                wr_en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (clr) begin
               state_nx = SWEEP;
               cnt_nx   = '0;
            end
         end
         SWEEP: begin
            cnt_nx = cnt + 1'b1;
            if (cnt == LAST) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy    = (state == SWEEP);
   assign wr_zero = (ZERO_LAST != 0) && (wrAddr == LAST);
   assign wr_en   = write && !busy && !wr_zero;
   assign wrDrop  = write && busy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (busy) begin
         regs[cnt] <= '0;
      end else if (wr_en) begin
         regs[wrAddr] <= wrData;
      end
   end

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;

      assign addr = rdAddr[g*ADDR_W +: ADDR_W];

      always_comb begin
         data = regs[addr];
         if ((ZERO_LAST != 0) && (addr == LAST)) data = '0;
`ifdef REGFILE_BYPASS_EN
         // wr_en already excludes the zero register and busy cycles
         if (wr_en && !reset && (addr == wrAddr)) data = wrData;
`endif
      end

      assign rdData[g*DATA_W +: DATA_W] = data;
   end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: default 64x32/2-port instance plus a 32x16/4-port instance.
module tb_regfile_param;

   logic          clk = 1'b0;
   logic          reset;
   logic          write;
   logic [4:0]    wrAddr;
   logic [63:0]   wrData;
   logic          clr;
   logic [9:0]    rdAddr;
   logic [127:0]  rdData;
   logic          busy;
   logic          wrDrop;

   logic          s_write;
   logic [3:0]    s_wrAddr;
   logic [31:0]   s_wrData;
   logic          s_clr;
   logic [15:0]   s_rdAddr;
   logic [127:0]  s_rdData;
   logic          s_busy;
   logic          s_wrDrop;

   int n_checks = 0;
   int n_pass   = 0;

   logic [63:0] m [32];
   int          sweep_left;

   always #5 clk = ~clk;

   regfile_param u_dut (
      .clk(clk), .reset(reset), .write(write), .wrAddr(wrAddr), .wrData(wrData),
      .clr(clr), .rdAddr(rdAddr), .rdData(rdData), .busy(busy), .wrDrop(wrDrop)
   );

   regfile_param #(.DATA_W(32), .ADDR_W(4), .NUM_RD(4), .ZERO_LAST(1)) u_small (
      .clk(clk), .reset(reset), .write(s_write), .wrAddr(s_wrAddr), .wrData(s_wrData),
      .clr(s_clr), .rdAddr(s_rdAddr), .rdData(s_rdData), .busy(s_busy), .wrDrop(s_wrDrop)
   );

   function automatic logic [63:0] exp_rd(input logic [4:0] a);
      if (a == 5'd31) return 64'h0;
`ifdef REGFILE_BYPASS_EN
      if (write && sweep_left == 0 && a == wrAddr) return wrData;
`endif
      return m[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m[i] = 64'h0;
      sweep_left = 0;
   endtask

   // Reference behaviour at a rising edge: sweep clears registers in order, else write then maybe start sweep.
   task automatic model_edge();
      if (sweep_left > 0) begin
         m[32 - sweep_left] = 64'h0;
         sweep_left--;
      end else begin
         if (write && wrAddr != 5'd31) m[wrAddr] = wrData;
         if (clr) sweep_left = 32;
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (!reset) model_edge();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; write = 1'b1; clr = 1'b1; wrAddr = 5'd4; wrData = 64'hDEAD;
      rdAddr = {5'd8, 5'd4};
      s_write = 1'b0; s_clr = 1'b0; s_wrAddr = '0; s_wrData = '0; s_rdAddr = '0;
      model_reset();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_checks++;
         if (rdData !== 128'h0 || busy !== 1'b0 || wrDrop !== 1'b0)
            $display("FAIL reset_hold: rdData=%h busy=%b wrDrop=%b required 0/0/0", rdData, busy, wrDrop);
         else n_pass++;
         step();
      end
      reset = 1'b0; write = 1'b0; clr = 1'b0; rdAddr = {5'd8, 5'd0};
      @(negedge clk);
      n_checks++;
      if (rdData !== 128'h0 || busy !== 1'b0)
         $display("FAIL reset_read: rdData=%h busy=%b required 0/0", rdData, busy);
      else n_pass++;
      step();
   endtask

   task automatic test_write_read();
      logic [4:0]  wa [3];
      logic [63:0] wd [3];
      wa = '{5'd0, 5'd8, 5'd15};
      wd = '{64'hFFFFFFFFFFFFFFFF, 64'hAAAAAAAAAAAAAAAA, 64'hCCCCCCCCCCCCCCCC};
      for (int i = 0; i < 3; i++) begin
         write = 1'b1; wrAddr = wa[i]; wrData = wd[i];
         @(negedge clk);
         step();
      end
      write = 1'b0; rdAddr = {5'd8, 5'd0};
      @(negedge clk);
      n_checks++;
      if (rdData !== {64'hAAAAAAAAAAAAAAAA, 64'hFFFFFFFFFFFFFFFF})
         $display("FAIL read_0_8: got %h required AAAA.../FFFF...", rdData);
      else n_pass++;
      rdAddr = {5'd8, 5'd15};
      #1;
      n_checks++;
      if (rdData !== {64'hAAAAAAAAAAAAAAAA, 64'hCCCCCCCCCCCCCCCC})
         $display("FAIL read_15_8: got %h required AAAA.../CCCC...", rdData);
      else n_pass++;
      step();
      write = 1'b1; wrAddr = 5'd31; wrData = 64'hF0F0F0F0F0F0F0F0;
      @(negedge clk);
      n_checks++;
      if (wrDrop !== 1'b0) $display("FAIL zero_reg_drop: wrDrop=%b required 0", wrDrop);
      else n_pass++;
      step();
      write = 1'b0; rdAddr = {5'd8, 5'd31};
      @(negedge clk);
      n_checks++;
      if (rdData[63:0] !== 64'h0) $display("FAIL zero_reg_read: got %h required 0", rdData[63:0]);
      else n_pass++;
      step();
   endtask

   task automatic test_bypass();
      logic [63:0] exp_same;
`ifdef REGFILE_BYPASS_EN
      exp_same = 64'h1234;
`else
      exp_same = 64'h0;
`endif
      write = 1'b1; wrAddr = 5'd3; wrData = 64'h1234; rdAddr = {5'd8, 5'd3};
      @(negedge clk);
      n_checks++;
      if (rdData[63:0] !== exp_same)
         $display("FAIL same_cycle_read: got %h required %h", rdData[63:0], exp_same);
      else n_pass++;
      step();
      write = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rdData[63:0] !== 64'h1234)
         $display("FAIL next_cycle_read: got %h required 1234", rdData[63:0]);
      else n_pass++;
      step();
   endtask

   task automatic test_random();
      logic [63:0] e0, e1;
      for (int c = 0; c < 300; c++) begin
         write  = 1'($urandom_range(0, 1));
         wrAddr = 5'($urandom_range(0, 31));
         wrData = {$urandom, $urandom};
         clr    = ($urandom_range(0, 79) == 0);
         rdAddr[4:0] = ($urandom_range(0, 3) == 0) ? wrAddr : 5'($urandom_range(0, 31));
         rdAddr[9:5] = 5'($urandom_range(0, 31));
         @(negedge clk);
         e0 = exp_rd(rdAddr[4:0]);
         e1 = exp_rd(rdAddr[9:5]);
         n_checks++;
         if (busy !== (sweep_left > 0) || wrDrop !== (write && sweep_left > 0))
            $display("FAIL rand_flags c=%0d: busy=%b wrDrop=%b required %b/%b", c, busy, wrDrop,
                     (sweep_left > 0), (write && sweep_left > 0));
         else n_pass++;
         n_checks++;
         if (rdData !== {e1, e0})
            $display("FAIL rand_read c=%0d: got %h required %h", c, rdData, {e1, e0});
         else n_pass++;
         step();
      end
      write = 1'b0; clr = 1'b0;
      for (int c = 0; c < 40 && sweep_left > 0; c++) step();
   endtask

   task automatic test_sweep();
      int busy_cycles = 0;
      logic [63:0] e0;
      write = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wrAddr = (i == 0) ? 5'd0 : (i == 1) ? 5'd8 : 5'd15;
         wrData = {$urandom, $urandom} | 64'h1;
         @(negedge clk);
         step();
      end
      write = 1'b0; clr = 1'b1;
      @(negedge clk);
      step();
      clr = 1'b0;
      for (int c = 0; c < 100; c++) begin
         write = (c == 10); wrAddr = 5'd5; wrData = 64'h5A5A;
         clr = (c == 15);
         rdAddr = {5'd5, 5'($urandom_range(0, 31))};
         @(negedge clk);
         if (busy !== 1'b1) break;
         busy_cycles++;
         e0 = exp_rd(rdAddr[4:0]);
         n_checks++;
         if (rdData[63:0] !== e0)
            $display("FAIL sweep_read c=%0d: got %h required %h", c, rdData[63:0], e0);
         else n_pass++;
         if (c == 10) begin
            n_checks++;
            if (wrDrop !== 1'b1) $display("FAIL sweep_wrdrop: wrDrop=%b required 1", wrDrop);
            else n_pass++;
         end
         step();
      end
      write = 1'b0; clr = 1'b0;
      n_checks++;
      if (busy_cycles != 32) $display("FAIL sweep_len: busy cycles %0d required 32", busy_cycles);
      else n_pass++;
      for (int a = 0; a < 32; a += 2) begin
         rdAddr = {5'(a + 1), 5'(a)};
         #1;
         n_checks++;
         if (rdData !== 128'h0) $display("FAIL sweep_zero a=%0d: got %h required 0", a, rdData);
         else n_pass++;
      end
      step();
   endtask

   task automatic test_clr_write();
      write = 1'b1; clr = 1'b1; wrAddr = 5'd7; wrData = 64'h7777_0000_1111_2222;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || wrDrop !== 1'b0)
         $display("FAIL clrwr_flags: busy=%b wrDrop=%b required 0/0", busy, wrDrop);
      else n_pass++;
      step();
      write = 1'b0; clr = 1'b0; rdAddr = {5'd0, 5'd7};
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || rdData[63:0] !== 64'h7777_0000_1111_2222)
         $display("FAIL clrwr_written: busy=%b data=%h required 1/7777000011112222", busy, rdData[63:0]);
      else n_pass++;
      for (int c = 0; c < 40 && sweep_left > 0; c++) step();
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || rdData[63:0] !== 64'h0)
         $display("FAIL clrwr_cleared: busy=%b data=%h required 0/0", busy, rdData[63:0]);
      else n_pass++;
      step();
   endtask

   task automatic test_reset_abort();
      write = 1'b1; wrAddr = 5'd20; wrData = 64'hABCD;
      @(negedge clk);
      step();
      write = 1'b0; clr = 1'b1;
      @(negedge clk);
      step();
      clr = 1'b0;
      for (int c = 0; c < 10; c++) step();
      reset = 1'b1; write = 1'b1; wrAddr = 5'd9; wrData = 64'h99; clr = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if (busy !== 1'b0 || wrDrop !== 1'b0 || rdData !== 128'h0)
         $display("FAIL abort_immediate: busy=%b wrDrop=%b rdData=%h required 0/0/0", busy, wrDrop, rdData);
      else n_pass++;
      step();
      step();
      reset = 1'b0; write = 1'b0; clr = 1'b0;
      for (int c = 0; c < 40; c++) begin
         rdAddr = {5'd20, 5'($urandom_range(0, 31))};
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b0 || rdData !== 128'h0)
            $display("FAIL abort_after c=%0d: busy=%b rdData=%h required 0/0", c, busy, rdData);
         else n_pass++;
         step();
      end
      write = 1'b1; wrAddr = 5'd20; wrData = 64'h55;
      @(negedge clk);
      step();
      write = 1'b0; rdAddr = {5'd0, 5'd20};
      @(negedge clk);
      n_checks++;
      if (rdData[63:0] !== 64'h55) $display("FAIL abort_write: got %h required 55", rdData[63:0]);
      else n_pass++;
      step();
   endtask

   task automatic test_small();
      logic [3:0]  sa [4];
      logic [31:0] sd [4];
      logic [127:0] exp4;
      int busy_cycles = 0;
      sa = '{4'd1, 4'd6, 4'd9, 4'd14};
      for (int i = 0; i < 4; i++) begin
         sd[i] = $urandom;
         s_write = 1'b1; s_wrAddr = sa[i]; s_wrData = sd[i];
         @(negedge clk);
         step();
      end
      s_write = 1'b0;
      s_rdAddr = {sa[3], sa[2], sa[1], sa[0]};
      exp4 = {sd[3], sd[2], sd[1], sd[0]};
      @(negedge clk);
      n_checks++;
      if (s_rdData !== exp4) $display("FAIL small_read4: got %h required %h", s_rdData, exp4);
      else n_pass++;
      s_rdAddr = {4'd15, sa[0], 4'd15, sa[3]};
      exp4 = {32'h0, sd[0], 32'h0, sd[3]};
      #1;
      n_checks++;
      if (s_rdData !== exp4) $display("FAIL small_read_zero: got %h required %h", s_rdData, exp4);
      else n_pass++;
      step();
      s_clr = 1'b1;
      @(negedge clk);
      step();
      s_clr = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (s_busy !== 1'b1) break;
         busy_cycles++;
         step();
      end
      n_checks++;
      if (busy_cycles != 16) $display("FAIL small_sweep_len: busy cycles %0d required 16", busy_cycles);
      else n_pass++;
      s_rdAddr = {sa[3], sa[2], sa[1], sa[0]};
      #1;
      n_checks++;
      if (s_rdData !== 128'h0) $display("FAIL small_cleared: got %h required 0", s_rdData);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_random();
      test_sweep();
      test_clr_write();
      test_reset_abort();
      test_small();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
